ripple_tick_ctrl: RTL and testbench

//  Upstream control stage for the rippling-LED display. Debounces four raw push

---
 rtl/ripple_tick_ctrl.sv | 125 ++++++++++++
 tb/tb_ripple_tick_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_tick_ctrl.sv
// rtl/ripple_tick_ctrl.sv - debounced button control and variable-rate shift tick for the LED ripple
// Four buttons are synchronised and debounced; their press pulses steer speed, pause and direction.
module ripple_tick_ctrl #(
  parameter int BASE_DIV   = 50000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_pause,
  input  logic       btn_dir,
  output logic       shift_tick,
  output logic       dir,
  output logic [1:0] speed,
  output logic       paused
);

  localparam int            DW         = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] C_DEB_LAST = DW'(DEB_CYCLES - 1);

  // Bit order everywhere: [0]=up, [1]=down, [2]=pause, [3]=dir
  logic [3:0]    w_btn;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_deb;
  logic [3:0]    r_deb_d;
  logic [3:0]    r_press;
  logic [DW-1:0] r_deb_cnt [4];

  logic [1:0]    r_speed;
  logic          r_paused;
  logic          r_dir;
  logic          r_tick;
  logic [31:0]   r_cnt;

  logic [31:0]   w_period;
  logic [31:0]   w_last;
  logic          w_up;
  logic          w_dn;

  assign w_btn = {btn_dir, btn_pause, btn_down, btn_up};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
    end
  end

  // A level is accepted only after DEB_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb <= '0;
      for (int i = 0; i < 4; i++) r_deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == C_DEB_LAST) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb_d <= '0;
      r_press <= '0;
    end else begin
      r_deb_d <= r_deb;
      r_press <= r_deb & ~r_deb_d;
    end
  end

  assign w_period = 32'(BASE_DIV) >> r_speed;
  assign w_last   = w_period - 32'd1;
  // Saturated presses are not a speed change, so they leave the counter alone.
  assign w_up     = r_press[0] & ~r_press[1] & (r_speed != 2'd3);
  assign w_dn     = r_press[1] & ~r_press[0] & (r_speed != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_speed  <= 2'd0;
      r_paused <= 1'b0;
      r_dir    <= 1'b0;
      r_tick   <= 1'b0;
      r_cnt    <= 32'd0;
    end else begin
      if (w_up) begin
        r_speed <= r_speed + 2'd1;
      end else if (w_dn) begin
        r_speed <= r_speed - 2'd1;
      end
      if (r_press[2]) r_paused <= ~r_paused;
      if (r_press[3]) r_dir    <= ~r_dir;

      if (w_up || w_dn) begin
        r_cnt  <= 32'd0;
        r_tick <= 1'b0;
      end else if (r_paused) begin
        r_tick <= 1'b0;
      end else if (r_cnt == w_last) begin
        r_cnt  <= 32'd0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 32'd1;
        r_tick <= 1'b0;
      end
    end
  end

  assign shift_tick = r_tick;
  assign dir        = r_dir;
  assign speed      = r_speed;
  assign paused     = r_paused;

endmodule

// File: tb/tb_ripple_tick_ctrl.sv
// tb/tb_ripple_tick_ctrl.sv - scoreboard bench for ripple_tick_ctrl
module tb_ripple_tick_ctrl;

  localparam int BASE_DIV = 16;
  localparam int DEB      = 4;
  // Button edge driven just after edge c takes effect on the control registers at edge c+LAT.
  localparam int LAT      = 2 + DEB + 2;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] btns;
  logic       shift_tick;
  logic       dir;
  logic [1:0] speed;
  logic       paused;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int tick_seen = 0;

  ev_t ev_q[$];
  int  q_tick[$];

  int         m_cnt    = 0;
  logic [1:0] m_speed  = 2'd0;
  logic       m_paused = 1'b0;
  logic       m_dir    = 1'b0;

  ripple_tick_ctrl #(.BASE_DIV(BASE_DIV), .DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up    (btns[0]),
    .btn_down  (btns[1]),
    .btn_pause (btns[2]),
    .btn_dir   (btns[3]),
    .shift_tick(shift_tick),
    .dir       (dir),
    .speed     (speed),
    .paused    (paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1);
  end

  // Reference model: predicts the edge on which shift_tick is set and queues it.
  always @(posedge clk) begin : model_blk
    int n;
    int p;
    logic up, dn, pa, di;
    logic [1:0] ns;
    n = cyc + 1;
    cyc <= n;
    if (!rst_n) begin
      m_cnt    <= 0;
      m_speed  <= 2'd0;
      m_paused <= 1'b0;
      m_dir    <= 1'b0;
    end else begin
      up = 1'b0; dn = 1'b0; pa = 1'b0; di = 1'b0;
      foreach (ev_q[i]) begin
        if (ev_q[i].cyc == n) begin
          case (ev_q[i].kind)
            0: up = 1'b1;
            1: dn = 1'b1;
            2: pa = 1'b1;
            default: di = 1'b1;
          endcase
        end
      end
      ns = m_speed;
      if (up && !dn && m_speed != 2'd3) ns = m_speed + 2'd1;
      if (dn && !up && m_speed != 2'd0) ns = m_speed - 2'd1;
      p = BASE_DIV >> m_speed;
      if (ns != m_speed) begin
        m_cnt <= 0;
      end else if (!m_paused) begin
        if (m_cnt == p - 1) begin
          m_cnt <= 0;
          q_tick.push_back(n);
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
      m_speed <= ns;
      if (pa) m_paused <= ~m_paused;
      if (di) m_dir <= ~m_dir;
    end
  end

  always @(negedge clk) begin : tick_mon
    logic exp_t;
    if (rst_n) begin
      exp_t = (q_tick.size() > 0) && (q_tick[0] == cyc);
      if (shift_tick === 1'b1) tick_seen++;
      if (shift_tick === 1'b1 || exp_t) begin
        checks++;
        if (shift_tick !== exp_t) begin
          failures++;
          $display("FAIL tick_at_cycle_%0d actual=%b required=%b", cyc, shift_tick, exp_t);
        end
        if (exp_t) void'(q_tick.pop_front());
      end
      while (q_tick.size() > 0 && q_tick[0] < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_tick cycle=%0d actual=0 required=1", q_tick[0]);
        void'(q_tick.pop_front());
      end
    end
  end

  task automatic press(input int idx, input int hold);
    ev_q.push_back('{cyc + LAT, idx});
    btns[idx] = 1'b1;
    repeat (hold) @(posedge clk);
    #1 btns[idx] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic wait_first_tick(input string name, input int rel);
    bit found = 1'b0;
    int at = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (shift_tick === 1'b1) begin
        found = 1'b1;
        at = cyc;
      end
    end
    checks++;
    if (!found || at - rel != 16) begin
      failures++;
      $display("FAIL %s actual=%0d required=16", name, found ? at - rel : -1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btns  = 4'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (shift_tick !== 1'b0) begin failures++; $display("FAIL reset_tick actual=%b required=0", shift_tick); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL reset_dir actual=%b required=0", dir); end
    checks++; if (speed !== 2'd0) begin failures++; $display("FAIL reset_speed actual=%0d required=0", speed); end
    checks++; if (paused !== 1'b0) begin failures++; $display("FAIL reset_paused actual=%b required=0", paused); end
  endtask

  task automatic test_free_run();
    int rel;
    rst_n = 1'b1;
    rel = cyc;
    wait_first_tick("first_tick_after_release", rel);
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (tick_seen !== 3) begin
      failures++;
      $display("FAIL free_run_tick_count actual=%0d required=3", tick_seen);
    end
  endtask

  task automatic test_speed();
    press(0, 10);
    checks++; if (speed !== 2'd1) begin failures++; $display("FAIL speed_after_one_up actual=%0d required=1", speed); end
    repeat (30) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) press(0, 10);
    checks++; if (speed !== 2'd3) begin failures++; $display("FAIL speed_saturate_high actual=%0d required=3", speed); end
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) press(1, 10);
    checks++; if (speed !== 2'd0) begin failures++; $display("FAIL speed_saturate_low actual=%0d required=0", speed); end
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic test_bounce();
    int lens[5] = '{1, 2, 3, 2, 1};
    foreach (lens[i]) begin
      btns[0] = 1'b1;
      repeat (lens[i]) @(posedge clk);
      #1 btns[0] = 1'b0;
      @(posedge clk);
      #1;
    end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (speed !== 2'd0) begin failures++; $display("FAIL bounce_ignored actual=%0d required=0", speed); end
    press(0, 10);
    checks++; if (speed !== 2'd1) begin failures++; $display("FAIL clean_after_bounce actual=%0d required=1", speed); end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_pause();
    int t0;
    press(2, 10);
    checks++; if (paused !== 1'b1) begin failures++; $display("FAIL pause_set actual=%b required=1", paused); end
    t0 = tick_seen;
    repeat (100) @(posedge clk);
    #1;
    checks++; if (tick_seen !== t0) begin failures++; $display("FAIL paused_no_ticks actual=%0d required=%0d", tick_seen - t0, 0); end
    press(2, 10);
    checks++; if (paused !== 1'b0) begin failures++; $display("FAIL pause_cleared actual=%b required=0", paused); end
    t0 = tick_seen;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (tick_seen - t0 < 1) begin failures++; $display("FAIL ticks_after_unpause actual=%0d required>=1", tick_seen - t0); end
  endtask

  task automatic test_back_to_back();
    ev_q.push_back('{cyc + LAT, 0});
    ev_q.push_back('{cyc + LAT, 1});
    btns[1:0] = 2'b11;
    repeat (10) @(posedge clk);
    #1 btns[1:0] = 2'b00;
    repeat (12) @(posedge clk);
    #1;
    checks++; if (speed !== 2'd1) begin failures++; $display("FAIL up_down_same_cycle actual=%0d required=1", speed); end
    press(3, 10);
    checks++; if (dir !== 1'b1) begin failures++; $display("FAIL dir_toggle actual=%b required=1", dir); end
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int rel;
    press(2, 10);
    press(0, 10);
    checks++; if (speed !== 2'd2) begin failures++; $display("FAIL speed_while_paused actual=%0d required=2", speed); end
    checks++; if (paused !== 1'b1 || dir !== 1'b1) begin failures++; $display("FAIL pre_reset_state actual=%b%b required=11", paused, dir); end
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q_tick.delete();
    ev_q.delete();
    #1;
    checks++; if (speed !== 2'd0) begin failures++; $display("FAIL mid_reset_speed actual=%0d required=0", speed); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL mid_reset_dir actual=%b required=0", dir); end
    checks++; if (paused !== 1'b0) begin failures++; $display("FAIL mid_reset_paused actual=%b required=0", paused); end
    checks++; if (shift_tick !== 1'b0) begin failures++; $display("FAIL mid_reset_tick actual=%b required=0", shift_tick); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    rel = cyc;
    wait_first_tick("first_tick_after_mid_reset", rel);
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_speed();
    test_bounce();
    test_pause();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
